// File: rtl/morse_rx_module_if.sv
`default_nettype none
// ============================================================================
// Module   : morse_rx_module_if
// Brief    : Keyed-line input and decoded-frame outputs of the Morse receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface morse_rx_module_if;
  logic        Pin_In;
  logic        Frame_Done_Sig;
  logic [15:0] Sym_Bits;
  logic [4:0]  Sym_Cnt;
  logic        SOS_Found_Sig;
  logic        Err_Sig;

  // master keys the line and consumes frames; slave is the decoder
  modport master (
    output Pin_In,
    input  Frame_Done_Sig, Sym_Bits, Sym_Cnt, SOS_Found_Sig, Err_Sig
  );

  modport slave (
    input  Pin_In,
    output Frame_Done_Sig, Sym_Bits, Sym_Cnt, SOS_Found_Sig, Err_Sig
  );
endinterface
`default_nettype wire

// File: rtl/morse_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : morse_rx_module
// Brief    : Times marks/spaces on a keyed line, classifies dot/dash and
//            reports up to 16 symbols per frame with SOS and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module morse_rx_module #(
  parameter logic [15:0] T1MS         = 16'd49_999,
  parameter logic [9:0]  MIN_MS       = 10'd20,
  parameter logic [9:0]  DOT_MAX_MS   = 10'd200,
  parameter logic [9:0]  DASH_MAX_MS  = 10'd600,
  parameter logic [9:0]  FRAME_GAP_MS = 10'd500
) (
  input  wire logic         CLK,
  input  wire logic         RSTn,
  morse_rx_module_if.slave  rx
);

  localparam logic [9:0] c_MS_MAX   = 10'd1023;
  localparam logic [4:0] c_SYM_MAX  = 5'd16;
  localparam logic [8:0] c_SOS_PAT  = 9'b000111000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_d;
  logic [15:0] r_tick;
  logic [9:0]  r_ms;
  logic [15:0] r_shift;
  logic [4:0]  r_cnt;
  logic        r_err;
  logic        r_done;
  logic [15:0] r_sym_bits;
  logic [4:0]  r_sym_cnt;
  logic        r_sos;
  logic        r_err_out;

  logic        w_rise;
  logic        w_fall;
  logic        w_tick_wrap;
  logic [15:0] w_tick_next;
  logic [9:0]  w_ms_next;
  logic        w_is_dash;

  // Sync FFs reset high so a line already high at reset release is not a rise
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= rx.Pin_In;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise      = r_sync2 & ~r_sync_d;
  assign w_fall      = ~r_sync2 & r_sync_d;
  assign w_tick_wrap = (r_tick == T1MS);
  assign w_tick_next = w_tick_wrap ? 16'd0 : r_tick + 16'd1;
  assign w_ms_next   = (w_tick_wrap && (r_ms != c_MS_MAX)) ? r_ms + 10'd1 : r_ms;
  assign w_is_dash   = (r_ms >= DOT_MAX_MS);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_tick     <= 16'd0;
      r_ms       <= 10'd0;
      r_shift    <= 16'd0;
      r_cnt      <= 5'd0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_sym_bits <= 16'd0;
      r_sym_cnt  <= 5'd0;
      r_sos      <= 1'b0;
      r_err_out  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tick <= 16'd0;
          r_ms   <= 10'd0;
          if (w_rise) begin
            r_state <= ST_MARK;
            r_shift <= 16'd0;
            r_cnt   <= 5'd0;
            r_err   <= 1'b0;
          end
        end

        ST_MARK: begin
          if (w_fall) begin
            r_tick <= 16'd0;
            r_ms   <= 10'd0;
            if (r_ms < MIN_MS) begin
              // noise: a lone glitch abandons the frame before it starts
              r_state <= (r_cnt != 5'd0) ? ST_SPACE : ST_IDLE;
            end else begin
              r_state <= ST_SPACE;
              if (r_ms >= DASH_MAX_MS || r_cnt == c_SYM_MAX) begin
                r_err <= 1'b1;
              end else begin
                r_shift <= {r_shift[14:0], w_is_dash};
                r_cnt   <= r_cnt + 5'd1;
              end
            end
          end else begin
            r_tick <= w_tick_next;
            r_ms   <= w_ms_next;
          end
        end

        ST_SPACE: begin
          // a rise coinciding with the gap terminal count keeps the frame open
          if (w_rise) begin
            r_state <= ST_MARK;
            r_tick  <= 16'd0;
            r_ms    <= 10'd0;
          end else if (r_ms >= FRAME_GAP_MS) begin
            r_state <= ST_DONE;
            r_tick  <= 16'd0;
            r_ms    <= 10'd0;
          end else begin
            r_tick <= w_tick_next;
            r_ms   <= w_ms_next;
          end
        end

        ST_DONE: begin
          r_sym_bits <= r_shift;
          r_sym_cnt  <= r_cnt;
          r_err_out  <= r_err;
          r_sos      <= (r_cnt == 5'd9) && (r_shift[8:0] == c_SOS_PAT) && !r_err;
          r_done     <= 1'b1;
          r_state    <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx.Frame_Done_Sig = r_done;
  assign rx.Sym_Bits       = r_sym_bits;
  assign rx.Sym_Cnt        = r_sym_cnt;
  assign rx.SOS_Found_Sig  = r_sos;
  assign rx.Err_Sig        = r_err_out;

endmodule
`default_nettype wire

// File: tb/tb_morse_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_rx_module
// Brief    : Directed bench for the Morse receiver at 10 clocks per ms.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_rx_module;

  localparam int c_CYC_PER_MS = 10;
  localparam int c_STROBE_TO  = 7000;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;

  morse_rx_module_if mif();

  morse_rx_module #(.T1MS(16'd9)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .rx   (mif.slave)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mif.Frame_Done_Sig === 1'b1) strobes <= strobes + 1;
  end

  task automatic mark(input int ms);
    mif.Pin_In = 1'b1;
    repeat (ms * c_CYC_PER_MS) @(negedge CLK);
  endtask

  task automatic space(input int ms);
    mif.Pin_In = 1'b0;
    repeat (ms * c_CYC_PER_MS) @(negedge CLK);
  endtask

  // Leaves the line high after the final mark; callers drop it.
  task automatic send_sos(input int dot_ms, input int dash_ms, input int gap_ms);
    for (int i = 0; i < 9; i++) begin
      mark((i >= 3 && i < 6) ? dash_ms : dot_ms);
      if (i < 8) space(gap_ms);
    end
  endtask

  task automatic wait_strobe(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < c_STROBE_TO && !ok) begin
      @(negedge CLK);
      cyc++;
      if (mif.Frame_Done_Sig === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    mif.Pin_In = 1'b0;
    RSTn = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (mif.Frame_Done_Sig !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", mif.Frame_Done_Sig); end
    checks++; if (mif.Sym_Bits !== 16'h0000) begin errors++; $display("FAIL rst_bits got %h want 0000", mif.Sym_Bits); end
    checks++; if (mif.Sym_Cnt !== 5'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", mif.Sym_Cnt); end
    checks++; if (mif.SOS_Found_Sig !== 1'b0) begin errors++; $display("FAIL rst_sos got %b want 0", mif.SOS_Found_Sig); end
    checks++; if (mif.Err_Sig !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", mif.Err_Sig); end
    RSTn = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_sos();
    int cyc; bit ok; int base;
    base = strobes;
    send_sos(100, 300, 50);
    mif.Pin_In = 1'b0;
    wait_strobe(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sos_strobe got none want strobe"); end
    checks++; if (mif.Sym_Cnt !== 5'd9) begin errors++; $display("FAIL sos_cnt got %0d want 9", mif.Sym_Cnt); end
    checks++; if (mif.Sym_Bits !== 16'h0038) begin errors++; $display("FAIL sos_bits got %h want 0038", mif.Sym_Bits); end
    checks++; if (mif.SOS_Found_Sig !== 1'b1) begin errors++; $display("FAIL sos_flag got %b want 1", mif.SOS_Found_Sig); end
    checks++; if (mif.Err_Sig !== 1'b0) begin errors++; $display("FAIL sos_err got %b want 0", mif.Err_Sig); end
    repeat (20) @(negedge CLK);
    checks++; if (strobes !== base + 1) begin errors++; $display("FAIL sos_strobe_count got %0d want %0d", strobes - base, 1); end
  endtask

  // Lone glitch must not open a frame; a dash follows straight after so a
  // wrongly counted glitch would show up as a second symbol.
  task automatic test_glitch_dash();
    int cyc; bit ok; int base;
    base = strobes;
    mark(5);
    space(100);
    checks++; if (strobes !== base) begin errors++; $display("FAIL glitch_strobe got %0d want 0", strobes - base); end
    checks++; if (mif.Sym_Cnt !== 5'd9) begin errors++; $display("FAIL hold_cnt got %0d want 9", mif.Sym_Cnt); end
    mark(250);
    mif.Pin_In = 1'b0;
    wait_strobe(cyc, ok);
    checks++; if (!ok || cyc < 4995 || cyc > 5015) begin errors++; $display("FAIL dash_latency got %0d cycles want 4995..5015", cyc); end
    checks++; if (mif.Sym_Cnt !== 5'd1) begin errors++; $display("FAIL dash_cnt got %0d want 1", mif.Sym_Cnt); end
    checks++; if (mif.Sym_Bits !== 16'h0001) begin errors++; $display("FAIL dash_bits got %h want 0001", mif.Sym_Bits); end
    checks++; if (mif.SOS_Found_Sig !== 1'b0) begin errors++; $display("FAIL dash_sos got %b want 0", mif.SOS_Found_Sig); end
    checks++; if (mif.Err_Sig !== 1'b0) begin errors++; $display("FAIL dash_err got %b want 0", mif.Err_Sig); end
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_overlong();
    int cyc; bit ok;
    mark(100); space(21);
    mark(700); space(21);
    mark(100);
    mif.Pin_In = 1'b0;
    wait_strobe(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL long_strobe got none want strobe"); end
    checks++; if (mif.Sym_Cnt !== 5'd2) begin errors++; $display("FAIL long_cnt got %0d want 2", mif.Sym_Cnt); end
    checks++; if (mif.Sym_Bits !== 16'h0000) begin errors++; $display("FAIL long_bits got %h want 0000", mif.Sym_Bits); end
    checks++; if (mif.Err_Sig !== 1'b1) begin errors++; $display("FAIL long_err got %b want 1", mif.Err_Sig); end
    checks++; if (mif.SOS_Found_Sig !== 1'b0) begin errors++; $display("FAIL long_sos got %b want 0", mif.SOS_Found_Sig); end
    repeat (10) @(negedge CLK);
  endtask

  // 21 ms marks measure as exactly MIN_MS, so each must count as a dot.
  task automatic test_overflow();
    int cyc; bit ok;
    for (int i = 0; i < 17; i++) begin
      mark(21);
      if (i < 16) space(21);
    end
    mif.Pin_In = 1'b0;
    wait_strobe(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_strobe got none want strobe"); end
    checks++; if (mif.Sym_Cnt !== 5'd16) begin errors++; $display("FAIL ovf_cnt got %0d want 16", mif.Sym_Cnt); end
    checks++; if (mif.Sym_Bits !== 16'h0000) begin errors++; $display("FAIL ovf_bits got %h want 0000", mif.Sym_Bits); end
    checks++; if (mif.Err_Sig !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", mif.Err_Sig); end
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_reset_abort();
    int base;
    base = strobes;
    mark(21); space(21);
    mark(21); space(21);
    mark(21); space(21);
    mark(201); space(21);
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (mif.Sym_Cnt !== 5'd0) begin errors++; $display("FAIL abort_cnt got %0d want 0", mif.Sym_Cnt); end
    checks++; if (mif.Err_Sig !== 1'b0) begin errors++; $display("FAIL abort_err got %b want 0", mif.Err_Sig); end
    checks++; if (mif.Sym_Bits !== 16'h0000) begin errors++; $display("FAIL abort_bits got %h want 0000", mif.Sym_Bits); end
    checks++; if (mif.SOS_Found_Sig !== 1'b0) begin errors++; $display("FAIL abort_sos got %b want 0", mif.SOS_Found_Sig); end
    RSTn = 1'b1;
    space(510);
    checks++; if (strobes !== base) begin errors++; $display("FAIL abort_strobe got %0d want 0", strobes - base); end
  endtask

  // 201 ms marks measure as exactly DOT_MAX_MS, so they must be dashes.
  task automatic test_glitch_sos();
    int cyc; bit ok;
    mark(21); space(21);
    mark(21); space(21);
    mark(21); space(20);
    mark(5);  space(20);
    mark(201); space(21);
    mark(201); space(21);
    mark(201); space(21);
    mark(21); space(21);
    mark(21); space(21);
    mark(21);
    mif.Pin_In = 1'b0;
    wait_strobe(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gsos_strobe got none want strobe"); end
    checks++; if (mif.Sym_Cnt !== 5'd9) begin errors++; $display("FAIL gsos_cnt got %0d want 9", mif.Sym_Cnt); end
    checks++; if (mif.Sym_Bits !== 16'h0038) begin errors++; $display("FAIL gsos_bits got %h want 0038", mif.Sym_Bits); end
    checks++; if (mif.SOS_Found_Sig !== 1'b1) begin errors++; $display("FAIL gsos_flag got %b want 1", mif.SOS_Found_Sig); end
    checks++; if (mif.Err_Sig !== 1'b0) begin errors++; $display("FAIL gsos_err got %b want 0", mif.Err_Sig); end
  endtask

  initial begin
    mif.Pin_In = 1'b0;
    @(negedge CLK);
    test_reset();
    test_sos();
    test_glitch_dash();
    test_overlong();
    test_overflow();
    test_reset_abort();
    test_glitch_sos();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
